multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the mini RISC-V core, and the issuing end of the ALU interface.
- Accepts one instruction per handshake, decodes it, and drives the ALU operation select, funct fields, operand-source select and sign-extended immediate.
- Sequences execute, memory and writeback, and reports branch outcome from the returned ALU result.
- Sits between instruction fetch and the ALU / register file / data memory.

---
 rtl/riscv_pkg.sv | 50 +++++
 rtl/multicycle_ctrl_if.sv | 33 +++
 rtl/imm_gen.sv | 31 +++
 rtl/multicycle_ctrl.sv | 139 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared constants for the mini RISC-V core: opcodes, ALU control
// encodings, funct fields, controller state type and a legality helper.
package riscv_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_ARITH = 2'b10;

    localparam logic [2:0] F3_ADD = 3'd0;
    localparam logic [2:0] F3_OR  = 3'd6;
    localparam logic [2:0] F3_AND = 3'd7;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_SW  = 3'd2;
    localparam logic [2:0] F3_BEQ = 3'd0;
    localparam logic [2:0] F3_BNE = 3'd1;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB, BR} state_t;

    // True when the instruction word is one the controller can sequence.
    function automatic logic is_legal(input logic [31:0] instr);
        logic [2:0] f3;
        logic [6:0] f7;
        logic       arith_f3;
        logic       ok;
        f3       = instr[14:12];
        f7       = instr[31:25];
        arith_f3 = (f3 == F3_ADD) || (f3 == F3_OR) || (f3 == F3_AND);
        ok       = 1'b0;
        case (instr[6:0])
            OP_RTYPE:  ok = arith_f3 &&
                            ((f7 == F7_BASE) || ((f7 == F7_ALT) && (f3 == F3_ADD)));
            OP_IARITH: ok = arith_f3;
            OP_LOAD:   ok = (f3 == F3_LW);
            OP_STORE:  ok = (f3 == F3_SW);
            OP_BRANCH: ok = (f3 == F3_BEQ) || (f3 == F3_BNE);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Fetch handshake plus ALU / register-file / memory control bundle.
interface multicycle_ctrl_if #(parameter int XLEN = 32);
    logic            instr_valid;
    logic [31:0]     instr;
    logic            instr_ready;
    logic [XLEN-1:0] ALUResult;
    logic [1:0]      ALUOp;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            ALUSrc;
    logic [XLEN-1:0] imm32;
    logic            RegWrite;
    logic            MemRead;
    logic            MemWrite;
    logic            MemtoReg;
    logic            branch_taken;
    logic            instr_done;
    logic            illegal;

    modport master (
        input  instr_valid, instr, ALUResult,
        output instr_ready, ALUOp, funct3, funct7, ALUSrc, imm32,
               RegWrite, MemRead, MemWrite, MemtoReg,
               branch_taken, instr_done, illegal
    );

    modport slave (
        output instr_valid, instr, ALUResult,
        input  instr_ready, ALUOp, funct3, funct7, ALUSrc, imm32,
               RegWrite, MemRead, MemWrite, MemtoReg,
               branch_taken, instr_done, illegal
    );
endinterface

// File: rtl/imm_gen.sv
// Immediate generator: sign-extends the I/S/B immediate selected by opcode.
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm32
);

    // rs1 and funct3 carry no immediate bits in the supported formats
    logic unused_bits;
    assign unused_bits = ^instr[19:12];

    // Reassemble the immediate field for the instruction format
    always_comb begin
        imm32 = '0;
        case (instr[6:0])
            OP_IARITH, OP_LOAD:
                imm32 = {{(XLEN-12){instr[31]}}, instr[31:20]};
            OP_STORE:
                imm32 = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                imm32 = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                         instr[30:25], instr[11:8], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: accepts an instruction, registers its decoded
// ALU controls, then sequences EXEC / MEM / WB / BR and reports completion.
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);

    state_t          state;
    logic [6:0]      opcode_q;
    logic            legal_q;
    logic            illegal_q;
    logic [1:0]      aluop_q;
    logic [2:0]      funct3_q;
    logic [6:0]      funct7_q;
    logic            alusrc_q;
    logic [XLEN-1:0] imm_q;

    logic [XLEN-1:0] imm_next;
    logic [1:0]      dec_aluop;
    logic            dec_alusrc;
    logic [6:0]      dec_funct7;
    logic            accept;
    logic            br_cond;

    assign accept = (state == IDLE) && bus.instr_valid;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (bus.instr),
        .imm32 (imm_next)
    );

    // Decode ALU controls from the instruction presented by fetch
    always_comb begin
        dec_aluop  = ALUOP_MEM;
        dec_alusrc = 1'b0;
        dec_funct7 = F7_BASE;
        case (bus.instr[6:0])
            OP_RTYPE: begin
                dec_aluop  = ALUOP_ARITH;
                dec_funct7 = bus.instr[31:25];
            end
            // instr[31:25] are immediate bits here, so funct7 stays 00
            OP_IARITH: begin
                dec_aluop  = ALUOP_ARITH;
                dec_alusrc = 1'b1;
            end
            OP_LOAD, OP_STORE: begin
                dec_aluop  = ALUOP_MEM;
                dec_alusrc = 1'b1;
            end
            OP_BRANCH: begin
                dec_aluop  = ALUOP_BR;
            end
            default: begin
                dec_aluop  = ALUOP_MEM;
            end
        endcase
    end

    // Capture decoded controls on acceptance and hold them for the instruction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opcode_q <= '0;
            legal_q  <= 1'b0;
            aluop_q  <= '0;
            funct3_q <= '0;
            funct7_q <= '0;
            alusrc_q <= 1'b0;
            imm_q    <= '0;
        end else if (accept) begin
            opcode_q <= bus.instr[6:0];
            legal_q  <= is_legal(bus.instr);
            aluop_q  <= dec_aluop;
            funct3_q <= bus.instr[14:12];
            funct7_q <= dec_funct7;
            alusrc_q <= dec_alusrc;
            imm_q    <= imm_next;
        end
    end

    // Sequence the instruction through its phases; flag illegal encodings
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            case (state)
                IDLE:
                    if (accept) state <= DECODE;
                DECODE:
                    if (legal_q) begin
                        state <= EXEC;
                    end else begin
                        state     <= IDLE;
                        illegal_q <= 1'b1;
                    end
                EXEC:
                    if (opcode_q == OP_LOAD || opcode_q == OP_STORE) state <= MEM;
                    else if (opcode_q == OP_BRANCH)                  state <= BR;
                    else                                             state <= WB;
                MEM:
                    state <= (opcode_q == OP_LOAD) ? WB : IDLE;
                WB:      state <= IDLE;
                BR:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Branch condition on the ALU difference returned during BR
    always_comb begin
        br_cond = 1'b0;
        if (funct3_q == F3_BEQ)      br_cond = (bus.ALUResult == '0);
        else if (funct3_q == F3_BNE) br_cond = (bus.ALUResult != '0);
    end

    // Strobes decode directly from registered state, so reset clears them at once
    assign bus.instr_ready  = (state == IDLE);
    assign bus.ALUOp        = aluop_q;
    assign bus.funct3       = funct3_q;
    assign bus.funct7       = funct7_q;
    assign bus.ALUSrc       = alusrc_q;
    assign bus.imm32        = imm_q;
    assign bus.MemRead      = (state == MEM) && (opcode_q == OP_LOAD);
    assign bus.MemWrite     = (state == MEM) && (opcode_q == OP_STORE);
    assign bus.RegWrite     = (state == WB);
    assign bus.MemtoReg     = (state == WB) && (opcode_q == OP_LOAD);
    assign bus.branch_taken = (state == BR) && br_cond;
    assign bus.instr_done   = (state == WB) || (state == BR) ||
                              ((state == MEM) && (opcode_q == OP_STORE));
    assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with a completion scoreboard.
module tb_multicycle_ctrl;

    localparam int C_R     = 0;
    localparam int C_LOAD  = 1;
    localparam int C_STORE = 2;
    localparam int C_BR    = 3;
    localparam int C_ILL   = 4;

    typedef struct {
        string tag;
        int    lat;
        bit    bt;
        bit    ill;
        bit    m2r;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    exp_t sb[$];

    multicycle_ctrl_if #(.XLEN(32)) bus ();

    multicycle_ctrl #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input int cls);
        case (cls)
            C_LOAD:  return 4;
            C_ILL:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, ":ready"},   32'(bus.instr_ready), 32'd1);
        chk({tag, ":ALUOp"},   32'(bus.ALUOp), 32'd0);
        chk({tag, ":funct3"},  32'(bus.funct3), 32'd0);
        chk({tag, ":funct7"},  32'(bus.funct7), 32'd0);
        chk({tag, ":ALUSrc"},  32'(bus.ALUSrc), 32'd0);
        chk({tag, ":imm32"},   bus.imm32, 32'd0);
        chk({tag, ":RegWrite"},32'(bus.RegWrite), 32'd0);
        chk({tag, ":MemRead"}, 32'(bus.MemRead), 32'd0);
        chk({tag, ":MemWrite"},32'(bus.MemWrite), 32'd0);
        chk({tag, ":MemtoReg"},32'(bus.MemtoReg), 32'd0);
        chk({tag, ":br_taken"},32'(bus.branch_taken), 32'd0);
        chk({tag, ":done"},    32'(bus.instr_done), 32'd0);
        chk({tag, ":illegal"}, 32'(bus.illegal), 32'd0);
    endtask

    task automatic run(input string tag, input logic [31:0] ins, input logic [31:0] alur,
                       input int cls, input bit bt, input bit chk_ctl,
                       input logic [1:0] e_op, input logic e_src, input logic [2:0] e_f3,
                       input logic [6:0] e_f7, input logic [31:0] e_imm);
        exp_t e;
        exp_t x;
        int   w;
        bit   seen;
        w = 0;
        while (bus.instr_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, ":accept_ready"}, 32'(bus.instr_ready), 32'd1);
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        bus.ALUResult   = alur;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bus.instr       = ~ins;
        e.tag = tag;
        e.lat = lat_of(cls);
        e.bt  = bt;
        e.ill = (cls == C_ILL);
        e.m2r = (cls == C_LOAD);
        sb.push_back(e);
        seen = 1'b0;
        for (int k = 1; k <= 8 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk({tag, ":busy"}, 32'(bus.instr_ready), 32'd0);
                if (chk_ctl) begin
                    chk({tag, ":ALUOp"},  32'(bus.ALUOp), 32'(e_op));
                    chk({tag, ":ALUSrc"}, 32'(bus.ALUSrc), 32'(e_src));
                    chk({tag, ":funct3"}, 32'(bus.funct3), 32'(e_f3));
                    chk({tag, ":funct7"}, 32'(bus.funct7), 32'(e_f7));
                    chk({tag, ":imm32"},  bus.imm32, e_imm);
                end
                // valid while busy must be ignored
                bus.instr_valid = 1'b1;
            end else begin
                bus.instr_valid = 1'b0;
            end
            chk({tag, ":MemRead"},  32'(bus.MemRead),  32'(cls == C_LOAD && k == 3));
            chk({tag, ":MemWrite"}, 32'(bus.MemWrite), 32'(cls == C_STORE && k == 3));
            chk({tag, ":RegWrite"}, 32'(bus.RegWrite),
                32'((cls == C_R && k == 3) || (cls == C_LOAD && k == 4)));
            if (bus.instr_done === 1'b1 || bus.illegal === 1'b1) begin
                x = sb.pop_front();
                chk({x.tag, ":latency"},  32'(k), 32'(x.lat));
                chk({x.tag, ":illegal"},  32'(bus.illegal), 32'(x.ill));
                chk({x.tag, ":done"},     32'(bus.instr_done), 32'(!x.ill));
                chk({x.tag, ":br_taken"}, 32'(bus.branch_taken), 32'(x.bt));
                chk({x.tag, ":MemtoReg"}, 32'(bus.MemtoReg), 32'(x.m2r));
                chk({x.tag, ":ready_at_end"}, 32'(bus.instr_ready), 32'(x.ill));
                if (chk_ctl) chk({x.tag, ":imm_held"}, bus.imm32, e_imm);
                seen = 1'b1;
            end else begin
                chk({tag, ":br_taken_early"}, 32'(bus.branch_taken), 32'd0);
            end
        end
        bus.instr_valid = 1'b0;
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s:timeout observed no completion expected latency %0d", tag, e.lat);
            sb.delete();
        end else if (cls != C_ILL) begin
            @(negedge clk);
            chk({tag, ":ready_after"}, 32'(bus.instr_ready), 32'd1);
            chk({tag, ":done_after"},  32'(bus.instr_done), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of run expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst             = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.ALUResult   = '0;
        #1;
        chk_zero("por");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run("add",     32'h002081B3, 32'd0, C_R,     1'b0, 1'b1, 2'b10, 1'b0, 3'd0, 7'h00, 32'h0);
        run("addi_m1", 32'hFFF08093, 32'd0, C_R,     1'b0, 1'b1, 2'b10, 1'b1, 3'd0, 7'h00, 32'hFFFFFFFF);
        run("sub",     32'h402081B3, 32'd0, C_R,     1'b0, 1'b1, 2'b10, 1'b0, 3'd0, 7'h20, 32'h0);
        run("lw",      32'h0080A283, 32'd0, C_LOAD,  1'b0, 1'b1, 2'b00, 1'b1, 3'd2, 7'h00, 32'h8);
        run("sw",      32'hFE20AE23, 32'd0, C_STORE, 1'b0, 1'b1, 2'b00, 1'b1, 3'd2, 7'h00, 32'hFFFFFFFC);
        run("beq_t",   32'hFE208CE3, 32'd0, C_BR,    1'b1, 1'b1, 2'b01, 1'b0, 3'd0, 7'h00, 32'hFFFFFFF8);
        run("beq_nt",  32'hFE208CE3, 32'd5, C_BR,    1'b0, 1'b1, 2'b01, 1'b0, 3'd0, 7'h00, 32'hFFFFFFF8);
        run("bne_t",   32'hFE209CE3, 32'd5, C_BR,    1'b1, 1'b1, 2'b01, 1'b0, 3'd1, 7'h00, 32'hFFFFFFF8);
        run("bne_nt",  32'hFE209CE3, 32'd0, C_BR,    1'b0, 1'b1, 2'b01, 1'b0, 3'd1, 7'h00, 32'hFFFFFFF8);
        run("ill_op",  32'h0000007F, 32'd0, C_ILL,   1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 7'h00, 32'h0);
        run("ill_sll", 32'h002091B3, 32'd0, C_ILL,   1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 7'h00, 32'h0);
        run("ill_f7",  32'h4020F1B3, 32'd0, C_ILL,   1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 7'h00, 32'h0);
        run("add_b2b", 32'h002081B3, 32'd0, C_R,     1'b0, 1'b1, 2'b10, 1'b0, 3'd0, 7'h00, 32'h0);

        // reset in the middle of a load's EXEC phase
        bus.instr_valid = 1'b1;
        bus.instr       = 32'h0080A283;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_zero("rst_mid");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b1;
            chk("rst_MemRead",  32'(bus.MemRead),    32'd0);
            chk("rst_RegWrite", 32'(bus.RegWrite),   32'd0);
            chk("rst_done",     32'(bus.instr_done), 32'd0);
            chk("rst_ready",    32'(bus.instr_ready), 32'd1);
        end

        run("add_post", 32'h002081B3, 32'd0, C_R, 1'b0, 1'b1, 2'b10, 1'b0, 3'd0, 7'h00, 32'h0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
